// File: rtl/axi_wr_arbiter_if.sv
// Write-path bundle between NUM_M write masters, the round-robin arbiter and one AXI3 slave port.
// Every channel: a transfer happens on the rising clk edge where valid and ready are both 1; valid never waits on ready.
interface axi_wr_arbiter_if #(parameter int NUM_M = 2);
    logic [NUM_M*32-1:0] m_awaddr;
    logic [NUM_M*4-1:0]  m_awlen;
    logic [NUM_M-1:0]    m_awvalid;
    logic [NUM_M-1:0]    m_awready;
    logic [NUM_M*32-1:0] m_wdata;
    logic [NUM_M*4-1:0]  m_wstrb;
    logic [NUM_M-1:0]    m_wvalid;
    logic [NUM_M-1:0]    m_wready;
    logic [1:0]          m_bresp;
    logic [NUM_M-1:0]    m_bvalid;
    logic [NUM_M-1:0]    m_bready;

    logic [3:0]          s_awid;
    logic [31:0]         s_awaddr;
    logic [3:0]          s_awlen;
    logic                s_awvalid;
    logic                s_awready;
    logic [3:0]          s_wid;
    logic [31:0]         s_wdata;
    logic [3:0]          s_wstrb;
    logic                s_wlast;
    logic                s_wvalid;
    logic                s_wready;
    logic [3:0]          s_bid;
    logic [1:0]          s_bresp;
    logic                s_bvalid;
    logic                s_bready;

    // The arbiter itself: slave to the write masters, master to the downstream port.
    modport slave (
        input  m_awaddr, m_awlen, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        input  s_awready, s_wready, s_bid, s_bresp, s_bvalid,
        output m_awready, m_wready, m_bresp, m_bvalid,
        output s_awid, s_awaddr, s_awlen, s_awvalid, s_wid, s_wdata, s_wstrb, s_wlast,
        output s_wvalid, s_bready
    );

    // The surroundings: the write masters plus the downstream slave.
    modport master (
        output m_awaddr, m_awlen, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        output s_awready, s_wready, s_bid, s_bresp, s_bvalid,
        input  m_awready, m_wready, m_bresp, m_bvalid,
        input  s_awid, s_awaddr, s_awlen, s_awvalid, s_wid, s_wdata, s_wstrb, s_wlast,
        input  s_wvalid, s_bready
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI3 write path between NUM_M masters, one burst in flight at a time.
// WLAST comes from an internal beat counter; AWID/WID carry the granted master index.
module axi_wr_arbiter #(
    parameter int NUM_M = 2
) (
    input  logic            clk,
    input  logic            prst,
    axi_wr_arbiter_if.slave bus,
    output logic [1:0]      dbg_state
);
    localparam int GW = (NUM_M > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;
    logic [3:0]      len;
    logic [3:0]      beat;

    logic [GW-1:0]   pick;
    logic            pick_found;
    logic [3:0]      pick_len;
    logic [NUM_M-1:0] grant_oh;
    logic [31:0]     g_awaddr;
    logic [3:0]      g_awlen;
    logic            g_awvalid;
    logic [31:0]     g_wdata;
    logic [3:0]      g_wstrb;
    logic            g_wvalid;
    logic            g_bready;
    logic [3:0]      grant_id;
    logic            last_beat;
    logic            b_match;

    assign dbg_state = state;
    assign grant_id  = 4'(grant);
    assign last_beat = (beat == len);
    assign b_match   = bus.s_bvalid & (bus.s_bid == grant_id);

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_M;
        return GW'(s);
    endfunction

    // Scan upward from the master after last_grant, wrapping at NUM_M.
    always_comb begin
        pick       = last_grant;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_M; k++) begin
            if (!pick_found && bus.m_awvalid[rr_idx(last_grant, k)]) begin
                pick       = rr_idx(last_grant, k);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        pick_len = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (pick == GW'(i)) pick_len = bus.m_awlen[4*i +: 4];
        end
    end

    always_comb begin
        grant_oh  = '0;
        g_awaddr  = '0;
        g_awlen   = '0;
        g_awvalid = 1'b0;
        g_wdata   = '0;
        g_wstrb   = '0;
        g_wvalid  = 1'b0;
        g_bready  = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant == GW'(i)) begin
                grant_oh[i] = 1'b1;
                g_awaddr    = bus.m_awaddr[32*i +: 32];
                g_awlen     = bus.m_awlen[4*i +: 4];
                g_awvalid   = bus.m_awvalid[i];
                g_wdata     = bus.m_wdata[32*i +: 32];
                g_wstrb     = bus.m_wstrb[4*i +: 4];
                g_wvalid    = bus.m_wvalid[i];
                g_bready    = bus.m_bready[i];
            end
        end
    end

    // Forwarding is purely combinational; everything is zero outside the phase that owns it.
    always_comb begin
        bus.m_awready = '0;
        bus.m_wready  = '0;
        bus.m_bresp   = '0;
        bus.m_bvalid  = '0;
        bus.s_awid    = '0;
        bus.s_awaddr  = '0;
        bus.s_awlen   = '0;
        bus.s_awvalid = 1'b0;
        bus.s_wid     = '0;
        bus.s_wdata   = '0;
        bus.s_wstrb   = '0;
        bus.s_wlast   = 1'b0;
        bus.s_wvalid  = 1'b0;
        bus.s_bready  = 1'b0;
        case (state)
            ADDR: begin
                bus.s_awid    = grant_id;
                bus.s_awaddr  = g_awaddr;
                bus.s_awlen   = g_awlen;
                bus.s_awvalid = g_awvalid;
                bus.m_awready = grant_oh & {NUM_M{bus.s_awready}};
            end
            DATA: begin
                bus.s_wid    = grant_id;
                bus.s_wdata  = g_wdata;
                bus.s_wstrb  = g_wstrb;
                bus.s_wlast  = last_beat;
                bus.s_wvalid = g_wvalid;
                bus.m_wready = grant_oh & {NUM_M{bus.s_wready}};
            end
            RESP: begin
                bus.m_bresp  = bus.s_bresp;
                bus.m_bvalid = grant_oh & {NUM_M{b_match}};
                // A response tagged for someone else is swallowed so it cannot block the channel.
                bus.s_bready = (bus.s_bvalid & ~b_match) ? 1'b1 : g_bready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge prst) begin
        if (prst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_M - 1);
            len        <= '0;
            beat       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant      <= pick;
                        last_grant <= pick;
                        len        <= pick_len;
                        beat       <= '0;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (g_awvalid & bus.s_awready) state <= DATA;
                end
                DATA: begin
                    if (g_wvalid & bus.s_wready) begin
                        beat <= beat + 4'd1;
                        if (last_beat) state <= RESP;
                    end
                end
                RESP: begin
                    if (b_match & g_bready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: master agents and a slave responder driven from $urandom,
// checked against a transaction-level model (round-robin order, per-burst beat queue, response routing).
module tb_axi_wr_arbiter;
    localparam int NM = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic       clk;
    logic       prst;
    logic [1:0] dbg_state;

    axi_wr_arbiter_if #(.NUM_M(NM)) bus ();

    axi_wr_arbiter #(.NUM_M(NM)) dut (
        .clk       (clk),
        .prst      (prst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Master agents: pending bursts and their beats ({strb, data}).
    logic [31:0] mq_addr[NM][$];
    logic [3:0]  mq_len[NM][$];
    logic [35:0] mq_beat[NM][$];
    int          m_phase[NM];   // 0 none, 1 address, 2 data, 3 response
    int          m_left[NM];

    // Reference model.
    bit          busy;
    int          exp_grant;
    int          model_last;
    logic [35:0] exp_q[$];
    logic [31:0] exp_addr;
    logic [3:0]  exp_len;
    bit          expect_aw;
    int          beats_seen;

    // Slave responder.
    bit          b_pending;
    int          b_delay;
    bit          b_stray;
    logic [1:0]  b_resp;

    // Stimulus knobs.
    int awr_mode, wr_mode, gap_pct, bdelay_max, stray_mode, bstall_pct, resp_rand;
    int cyc, last_aw_cyc, n_aw;
    bit rr_timing;

    task automatic set_knobs(input int awr, input int wr, input int gap, input int bdel,
                             input int stray, input int bstall, input int rr);
        awr_mode = awr; wr_mode = wr; gap_pct = gap; bdelay_max = bdel;
        stray_mode = stray; bstall_pct = bstall; resp_rand = rr;
    endtask

    task automatic queue_burst(input int m, input logic [31:0] addr, input logic [3:0] len);
        logic [31:0] d;
        logic [3:0]  s;
        mq_addr[m].push_back(addr);
        mq_len[m].push_back(len);
        for (int b = 0; b <= int'(len); b++) begin
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            mq_beat[m].push_back({s, d});
        end
    endtask

    task automatic clear_inputs();
        bus.m_awaddr = '0; bus.m_awlen = '0; bus.m_awvalid = '0;
        bus.m_wdata = '0; bus.m_wstrb = '0; bus.m_wvalid = '0; bus.m_bready = '0;
        bus.s_awready = 1'b0; bus.s_wready = 1'b0;
        bus.s_bid = '0; bus.s_bresp = '0; bus.s_bvalid = 1'b0;
    endtask

    task automatic clear_model();
        for (int m = 0; m < NM; m++) begin
            mq_addr[m].delete(); mq_len[m].delete(); mq_beat[m].delete();
            m_phase[m] = 0; m_left[m] = 0;
        end
        exp_q.delete();
        busy = 1'b0; expect_aw = 1'b0; b_pending = 1'b0; b_stray = 1'b0;
        model_last = NM - 1; exp_grant = 0; beats_seen = 0;
    endtask

    // Drive all inputs for the coming cycle (called just after the rising edge).
    task automatic drive();
        logic [NM*32-1:0] a_addr, a_data;
        logic [NM*4-1:0]  a_len, a_strb;
        logic [NM-1:0]    awv, wv, br;
        logic [35:0]      bt;
        a_addr = '0; a_data = '0; a_len = '0; a_strb = '0; awv = '0; wv = '0; br = '0;
        for (int m = 0; m < NM; m++) begin
            if (m_phase[m] == 0 && mq_len[m].size() > 0) m_phase[m] = 1;
            if (mq_len[m].size() > 0) begin
                a_addr[32*m +: 32] = mq_addr[m][0];
                a_len[4*m +: 4]    = mq_len[m][0];
            end
            if (mq_beat[m].size() > 0) begin
                bt = mq_beat[m][0];
                a_data[32*m +: 32] = bt[31:0];
                a_strb[4*m +: 4]   = bt[35:32];
            end
            awv[m] = (m_phase[m] == 1);
            wv[m]  = (m_phase[m] == 2) && ($urandom_range(0, 99) >= gap_pct);
            br[m]  = ($urandom_range(0, 99) >= bstall_pct);
        end
        bus.m_awaddr = a_addr; bus.m_awlen = a_len; bus.m_awvalid = awv;
        bus.m_wdata = a_data; bus.m_wstrb = a_strb; bus.m_wvalid = wv; bus.m_bready = br;
        bus.s_awready = (awr_mode == 0) ? 1'b1 : (awr_mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        bus.s_wready  = (wr_mode == 0)  ? 1'b1 : (wr_mode == 1)  ? cyc[0] : 1'($urandom_range(0, 1));
        if (b_pending && b_delay == 0) begin
            bus.s_bvalid = 1'b1;
            bus.s_bid    = b_stray ? 4'd2 : 4'(exp_grant);
            bus.s_bresp  = b_resp;
        end else begin
            if (b_pending) b_delay--;
            bus.s_bvalid = 1'b0;
            bus.s_bid    = '0;
            bus.s_bresp  = '0;
        end
    endtask

    // Sample settled outputs mid-cycle and score whatever handshakes the next edge will take.
    task automatic observe();
        logic [NM-1:0] oh;
        logic [35:0]   e;
        bit            was_busy;
        int            idx;
        was_busy = busy;
        oh = busy ? (NM'(1) << exp_grant) : '0;
        check("ungranted_quiet", 64'((bus.m_awready | bus.m_wready | bus.m_bvalid) & ~oh), 64'(0));
        if (!busy)
            check("idle_quiet", 64'({bus.s_awvalid, bus.s_wvalid, bus.s_wlast, bus.s_bready}), 64'(0));
        if (expect_aw) begin
            check("aw_latency_valid", 64'(bus.s_awvalid), 64'(1));
            check("aw_latency_id", 64'(bus.s_awid), 64'(exp_grant));
            expect_aw = 1'b0;
        end
        if (bus.s_awvalid && bus.s_awready) begin
            check("aw_id", 64'(bus.s_awid), 64'(exp_grant));
            check("aw_addr", 64'(bus.s_awaddr), 64'(exp_addr));
            check("aw_len", 64'(bus.s_awlen), 64'(exp_len));
            check("aw_ready_route", 64'(bus.m_awready), 64'(oh));
            if (rr_timing && n_aw > 0) check("rr_spacing", 64'(cyc - last_aw_cyc), 64'(4));
            last_aw_cyc = cyc;
            n_aw++;
        end
        for (int m = 0; m < NM; m++) begin
            if (bus.m_awvalid[m] && bus.m_awready[m]) begin
                m_phase[m] = 2;
                m_left[m]  = int'(mq_len[m][0]) + 1;
            end
        end
        if (bus.s_wvalid && bus.s_wready) begin
            if (exp_q.size() == 0) begin
                check("w_extra_beat", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("w_data", 64'({bus.s_wstrb, bus.s_wdata}), 64'(e));
                check("w_id", 64'(bus.s_wid), 64'(exp_grant));
                check("w_last", 64'(bus.s_wlast), 64'(exp_q.size() == 0));
                beats_seen++;
                if (exp_q.size() == 0) begin
                    b_pending = 1'b1;
                    b_delay   = $urandom_range(0, bdelay_max);
                    b_stray   = (stray_mode == 1) || (stray_mode == 2 && $urandom_range(0, 1) == 1);
                    b_resp    = (resp_rand != 0 && $urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
                end
            end
        end
        for (int m = 0; m < NM; m++) begin
            if (bus.m_wvalid[m] && bus.m_wready[m]) begin
                void'(mq_beat[m].pop_front());
                m_left[m]--;
                if (m_left[m] == 0) m_phase[m] = 3;
            end
        end
        if (bus.s_bvalid) begin
            if (b_stray) begin
                check("stray_bready", 64'(bus.s_bready), 64'(1));
                check("stray_bvalid", 64'(bus.m_bvalid), 64'(0));
                check("stray_state", 64'(dbg_state), 64'(ST_RESP));
                b_stray = 1'b0;
            end else begin
                check("b_route", 64'(bus.m_bvalid), 64'(oh));
                check("b_resp", 64'(bus.m_bresp), 64'(b_resp));
                check("b_state", 64'(dbg_state), 64'(ST_RESP));
                check("b_ready", 64'(bus.s_bready), 64'(bus.m_bready[exp_grant]));
                if (bus.s_bready) begin
                    check("burst_beats", 64'(beats_seen), 64'(int'(exp_len) + 1));
                    b_pending = 1'b0;
                    busy      = 1'b0;
                end
            end
        end
        for (int m = 0; m < NM; m++) begin
            if (bus.m_bvalid[m] && bus.m_bready[m]) begin
                void'(mq_addr[m].pop_front());
                void'(mq_len[m].pop_front());
                m_phase[m] = 0;
            end
        end
        // Round-robin: first requester scanning up from the previous winner.
        if (!was_busy && (|bus.m_awvalid)) begin
            idx = -1;
            for (int k = 1; k <= NM; k++) begin
                if (idx < 0 && bus.m_awvalid[(model_last + k) % NM]) idx = (model_last + k) % NM;
            end
            exp_grant  = idx;
            model_last = idx;
            busy       = 1'b1;
            expect_aw  = 1'b1;
            exp_addr   = mq_addr[idx][0];
            exp_len    = mq_len[idx][0];
            beats_seen = 0;
            for (int b = 0; b <= int'(exp_len); b++) exp_q.push_back(mq_beat[idx][b]);
        end
    endtask

    function automatic bit all_done();
        bit d;
        d = !busy && !b_pending;
        for (int m = 0; m < NM; m++) if (mq_len[m].size() != 0 || m_phase[m] != 0) d = 1'b0;
        return d;
    endfunction

    task automatic run_traffic(input string name, input int max_cyc, input int abort_beats);
        bit finished;
        finished = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            drive();
            @(negedge clk);
            observe();
            if (abort_beats > 0 && beats_seen == abort_beats) begin
                finished = 1'b1;
                break;
            end
            if (all_done()) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) $display("FAIL timeout in %s", name);
        if (!finished) check("timeout", 64'(1), 64'(0));
    endtask

    initial begin
        cyc = 0; n_aw = 0; last_aw_cyc = 0; rr_timing = 1'b0;
        set_knobs(0, 0, 0, 0, 0, 0, 0);
        clear_inputs();
        clear_model();
        prst = 1'b1;
        #1;
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        check("reset_outs_a", 64'({bus.m_awready, bus.m_wready, bus.m_bresp, bus.m_bvalid, bus.s_awid,
                                   bus.s_awaddr, bus.s_awlen, bus.s_awvalid, bus.s_wid}), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        prst = 1'b0;

        // Reset abandons a 4-beat burst in the middle of its data phase.
        queue_burst(0, 32'h0000_0100, 4'd3);
        run_traffic("reset_mid_data", 200, 2);
        @(posedge clk);
        #2;
        prst = 1'b1;
        #1;
        check("rst_async_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_async_outs_a", 64'({bus.m_awready, bus.m_wready, bus.m_bresp, bus.m_bvalid, bus.s_awid,
                                       bus.s_awaddr, bus.s_awlen, bus.s_awvalid, bus.s_wid}), 64'(0));
        check("rst_async_outs_b", 64'({bus.s_wdata, bus.s_wstrb, bus.s_wlast, bus.s_wvalid, bus.s_bready}), 64'(0));
        clear_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        prst = 1'b0;
        // Both request after reset: master 0 must win first.
        queue_burst(1, 32'h0000_0200, 4'd0);
        queue_burst(0, 32'h0000_0300, 4'd0);
        run_traffic("after_reset", 200, 0);

        // Single master 1, ready slave, OKAY response.
        queue_burst(1, 32'h0000_1000, 4'd3);
        run_traffic("single_master", 200, 0);

        // Both masters streaming 1-beat bursts: alternating grants, 4 cycles apart.
        for (int i = 0; i < 4; i++) begin
            queue_burst(0, 32'h0000_2000 + 32'(i * 4), 4'd0);
            queue_burst(1, 32'h0000_3000 + 32'(i * 4), 4'd0);
        end
        rr_timing = 1'b1; n_aw = 0;
        run_traffic("round_robin", 300, 0);
        rr_timing = 1'b0;

        // Alternating slave backpressure on an 8-beat burst.
        set_knobs(1, 1, 0, 0, 0, 0, 1);
        queue_burst(0, 32'h0000_4000, 4'd7);
        run_traffic("backpressure", 300, 0);

        // Stray BID while master 0 waits for its response.
        set_knobs(0, 0, 0, 1, 1, 0, 1);
        queue_burst(0, 32'h0000_5000, 4'd1);
        run_traffic("stray_bid", 200, 0);

        // Longest burst: 16 beats.
        set_knobs(2, 2, 20, 2, 0, 20, 1);
        queue_burst(1, 32'h0000_6000, 4'd15);
        run_traffic("max_len", 500, 0);

        // Mixed random traffic from both masters.
        set_knobs(2, 2, 30, 3, 2, 30, 1);
        for (int i = 0; i < 16; i++)
            queue_burst($urandom_range(0, NM - 1), $urandom, 4'($urandom_range(0, 15)));
        run_traffic("random_mix", 5000, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Round-robin arbiter that shares one AXI3 write path (AW, W and B channels) between NUM_M write masters and a single 32-bit AXI3 slave port. It sits between the master-side write agents and the slave-side axi_interface bundle. Exactly one write burst is in flight at a time; address, data and response phases are sequenced by an internal state machine. The block generates WLAST itself from a beat counter, and stamps the granted master index on AWID and WID.

## Interface
- NUM_M, 2: number of requesting masters, legal range 2..4.
- clk  in  1  clock; all state updates on posedge.
- prst  in  1  asynchronous reset, active-high.
- m_awaddr  in  NUM_M*32  per-master write address; master i occupies bits [32i+31:32i].
- m_awlen  in  NUM_M*4  per-master burst length minus 1.
- m_awvalid  in  NUM_M  per-master write-address valid.
- m_awready  out  NUM_M  per-master write-address ready.
- m_wdata  in  NUM_M*32  per-master write data.
- m_wstrb  in  NUM_M*4  per-master byte strobes.
- m_wvalid  in  NUM_M  per-master write-data valid.
- m_wready  out  NUM_M  per-master write-data ready.
- m_bresp  out  2  write response, shared bus; valid only for the master whose m_bvalid bit is set.
- m_bvalid  out  NUM_M  per-master response valid.
- m_bready  in  NUM_M  per-master response ready.
- s_awid  out  4  AWID; equals the granted master index.
- s_awaddr  out  32  AWADDR.
- s_awlen  out  4  AWLEN.
- s_awvalid  out  1  AWVALID.
- s_awready  in  1  AWREADY.
- s_wid  out  4  WID; equals the granted master index.
- s_wdata  out  32  WDATA.
- s_wstrb  out  4  WSTRB.
- s_wlast  out  1  WLAST, generated by the block.
- s_wvalid  out  1  WVALID.
- s_wready  in  1  WREADY.
- s_bid  in  4  BID.
- s_bresp  in  2  BRESP.
- s_bvalid  in  1  BVALID.
- s_bready  out  1  BREADY.

## Operation
- The FSM has four states: IDLE, ADDR, DATA, RESP. Registers: state, grant (index), last_grant, len (4 bits), beat (4 bits).
- **IDLE**
  - If any m_awvalid bit is set, choose the first set bit scanning upward from last_grant+1, modulo NUM_M.
  - Register the choice into grant and last_grant. Latch that master's m_awlen into len. Clear beat. Go to ADDR.
  - No outputs are asserted in IDLE.
- **ADDR**
  - s_awvalid = m_awvalid[grant].
  - s_awaddr and s_awlen are muxed from master grant.
  - m_awready[grant] = s_awready; all other m_awready bits are 0.
  - On s_awvalid & s_awready, go to DATA.
- **DATA**
  - s_wvalid = m_wvalid[grant]; m_wready[grant] = s_wready.
  - s_wdata and s_wstrb are muxed from master grant.
  - s_wlast = (beat == len).
  - Each W handshake increments beat.
  - A handshake with s_wlast=1 goes to RESP.
- **RESP**
  - s_bready = m_bready[grant]; m_bvalid[grant] = s_bvalid & (s_bid == grant); m_bresp = s_bresp.
  - If s_bvalid is asserted with s_bid != grant, s_bready is forced to 1 and the response is dropped. The response is not forwarded and the FSM stays in RESP.
  - On a forwarded B handshake, go to IDLE.
- Masters not granted see ready=0 and bvalid=0 in every state.
- A new request raised mid-burst waits; it is arbitrated in the next IDLE.
- The block never modifies the burst length. Masters supply exactly awlen+1 beats; any extra beats stall, because m_wready=0 outside DATA.

## Timing
- **Reset (async, immediate):**
  - State → IDLE; grant=0; last_grant=NUM_M-1, so master 0 wins first; len=0; beat=0.
  - All ready/valid outputs and s_wlast are 0.
  - s_awid, s_wid, s_awaddr, s_awlen, s_wdata, s_wstrb and m_bresp are 0.
  - Reset asserted mid-burst abandons the burst with no further handshakes.
- **Arbitration latency:** m_awvalid seen in IDLE at edge N gives s_awvalid=1 in cycle N+1.
- **Valid/ready forwarding** in ADDR, DATA and RESP is combinational through the grant mux; there is no added pipeline stage.
- **Minimum burst time:** a 1-beat burst with an always-ready slave takes 4 cycles (IDLE, ADDR, DATA, RESP) before the next grant.
- **Wrap-around:**
  - beat is 4 bits; len=15 gives 16 beats.
  - last_grant wraps from NUM_M-1 to 0.
- **Simultaneous requests:** only one grant per IDLE cycle; the losers keep m_awvalid asserted.

## Test plan
- **Reset:** assert prst mid-DATA of a 4-beat burst. All outputs go to 0 immediately. After release, a master 0 request gets s_awvalid one cycle later with s_awid=0.
- **Single master:** master 1 writes awaddr=0x1000, awlen=3, ready slave. Required: s_awid=1, s_wid=1, 4 W beats, s_wlast only on beat 4, bresp=OKAY routed to m_bvalid[1] only.
- **Round-robin:** both masters hold m_awvalid continuously with awlen=0. Grants alternate 0,1,0,1 and each grant starts 4 cycles apart.
- **Backpressure:** toggle s_awready and s_wready every other cycle on an awlen=7 burst. Exactly 8 beats transfer, data is in order, and no beat is duplicated.
- **Stray BID:** in RESP for grant 0, drive s_bvalid with s_bid=2. Required: s_bready=1, m_bvalid=0, FSM stays in RESP. A following s_bid=0 response completes the burst.
- **Max length:** awlen=15 produces 16 beats, with s_wlast only on the 16th.
